// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the EX stage and the multiply/divide sequencer.
// The EX stage (master) drives the request and operands; the sequencer (slave)
// returns status, stall and the two result words.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [3:0]       i_func;
    logic [WIDTH-1:0] i_op_a;
    logic [WIDTH-1:0] i_op_b;
    logic             o_busy;
    logic             o_stall;
    logic             o_done;
    logic [WIDTH-1:0] o_result_lo;
    logic [WIDTH-1:0] o_result_hi;
    logic             o_div_zero;
    logic             o_ovf;

    modport master (
        output i_start, i_func, i_op_a, i_op_b,
        input  o_busy, o_stall, o_done, o_result_lo, o_result_hi, o_div_zero, o_ovf
    );

    modport slave (
        input  i_start, i_func, i_op_a, i_op_b,
        output o_busy, o_stall, o_done, o_result_lo, o_result_hi, o_div_zero, o_ovf
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / divide sequencer that sits beside EX.
// Operands are converted to magnitudes, run through WIDTH iterations of
// shift-add (multiply) or restoring division (divide), then signs are applied
// in a single fix-up cycle before the results are presented for one cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    muldiv_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0]       FUNC_MUL   = 4'b1000;
    localparam logic [3:0]       FUNC_DIV   = 4'b0100;
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);

    // Sequencer state and operation context captured at accept time
    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic               r_isDiv;
    logic               r_resNeg;
    logic               r_remNeg;
    logic               r_ovfCase;
    // Multiply: {accumulator, multiplier}; divide: low half is dividend/quotient
    logic [2*WIDTH-1:0] r_prod;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [WIDTH-1:0]   r_other;
    logic [WIDTH-1:0]   r_rem;

    // Architectural outputs, held until the next accepted operation rewrites them
    logic [WIDTH-1:0]   r_resultLo;
    logic [WIDTH-1:0]   r_resultHi;
    logic               r_divZero;
    logic               r_ovf;

    logic               w_isMul;
    logic               w_isDiv;
    logic               w_funcValid;
    logic               w_divZero;
    logic               w_accept;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_mulAdd;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_remDiff;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_prodSigned;
    logic [WIDTH-1:0]   w_quoMag;
    logic [WIDTH-1:0]   w_quoSigned;
    logic [WIDTH-1:0]   w_remSigned;

    // Request decode: only multiply and divide function codes are recognised
    assign w_isMul     = (bus.i_func == FUNC_MUL);
    assign w_isDiv     = (bus.i_func == FUNC_DIV);
    assign w_funcValid = w_isMul | w_isDiv;
    assign w_divZero   = w_isDiv & (bus.i_op_b == '0);
    assign w_accept    = (r_state == S_IDLE) & bus.i_start & w_funcValid;

    // Magnitudes of the incoming operands; the most negative value maps to 2^(W-1)
    assign w_magA = bus.i_op_a[WIDTH-1] ? -bus.i_op_a : bus.i_op_a;
    assign w_magB = bus.i_op_b[WIDTH-1] ? -bus.i_op_b : bus.i_op_b;

    // Shift-add step: add multiplicand to upper half when the current multiplier bit is set
    assign w_mulAdd = r_prod[0] ? {1'b0, r_other} : '0;
    assign w_mulSum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_mulAdd;

    // Restoring-divide step: shift next dividend bit in and trial-subtract the divisor
    assign w_remShift = {r_rem, r_prod[WIDTH-1]};
    assign w_remDiff  = w_remShift - {1'b0, r_other};
    assign w_fits     = ~w_remDiff[WIDTH];

    // Sign fix-up applied to the unsigned results in the FIX cycle
    assign w_prodSigned = r_resNeg ? -r_prod : r_prod;
    assign w_quoMag     = r_prod[WIDTH-1:0];
    assign w_quoSigned  = r_resNeg ? -w_quoMag : w_quoMag;
    assign w_remSigned  = r_remNeg ? -r_rem : r_rem;

    assign bus.o_busy      = (r_state != S_IDLE);
    assign bus.o_stall     = w_accept | (r_state == S_RUN) | (r_state == S_FIX);
    assign bus.o_done      = (r_state == S_DONE);
    assign bus.o_result_lo = r_resultLo;
    assign bus.o_result_hi = r_resultHi;
    assign bus.o_div_zero  = r_divZero;
    assign bus.o_ovf       = r_ovf;

    // Main sequencer: accept in IDLE, iterate in RUN, apply signs in FIX, pulse DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_isDiv    <= 1'b0;
            r_resNeg   <= 1'b0;
            r_remNeg   <= 1'b0;
            r_ovfCase  <= 1'b0;
            r_prod     <= '0;
            r_other    <= '0;
            r_rem      <= '0;
            r_resultLo <= '0;
            r_resultHi <= '0;
            r_divZero  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_divZero) begin
                            r_resultLo <= '1;
                            r_resultHi <= bus.i_op_a;
                            r_divZero  <= 1'b1;
                            r_ovf      <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            r_isDiv   <= w_isDiv;
                            r_resNeg  <= bus.i_op_a[WIDTH-1] ^ bus.i_op_b[WIDTH-1];
                            r_remNeg  <= bus.i_op_a[WIDTH-1];
                            r_ovfCase <= w_isDiv & (bus.i_op_a == MOST_NEG) & (bus.i_op_b == '1);
                            r_prod    <= {{WIDTH{1'b0}}, (w_isDiv ? w_magA : w_magB)};
                            r_other   <= w_isDiv ? w_magB : w_magA;
                            r_rem     <= '0;
                            r_count   <= '0;
                            r_divZero <= 1'b0;
                            r_ovf     <= 1'b0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_isDiv) begin
                        r_rem              <= w_fits ? w_remDiff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
                        r_prod[WIDTH-1:0]  <= {r_prod[WIDTH-2:0], w_fits};
                    end else begin
                        r_prod <= {w_mulSum, r_prod[WIDTH-1:1]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_COUNT) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_isDiv) begin
                        if (r_ovfCase) begin
                            r_resultLo <= MOST_NEG;
                            r_resultHi <= '0;
                            r_ovf      <= 1'b1;
                        end else begin
                            r_resultLo <= w_quoSigned;
                            r_resultHi <= w_remSigned;
                        end
                    end else begin
                        r_resultLo <= w_prodSigned[WIDTH-1:0];
                        r_resultHi <= w_prodSigned[2*WIDTH-1:WIDTH];
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, protocol
// corner sequences, and randomized operations against a signed-arithmetic model.
module tb_muldiv_sequencer;

    localparam int W = 16;
    localparam logic [3:0] F_MUL = 4'b1000;
    localparam logic [3:0] F_DIV = 4'b0100;

    logic clk = 1'b0;
    logic reset;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  func;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_func  = f;
        bus.i_op_a  = a;
        bus.i_op_b  = b;
    endtask

    // Reference: plain signed arithmetic with the special divide cases
    task automatic refModel(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] lo, output logic [15:0] hi,
                            output logic dz, output logic ov, output int lat);
        int sa;
        int sb;
        int p;
        int q;
        int r;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        dz  = 1'b0;
        ov  = 1'b0;
        lat = W + 2;
        if (f == F_MUL) begin
            p  = sa * sb;
            lo = p[15:0];
            hi = p[31:16];
        end else if (b == 16'h0000) begin
            lo  = 16'hFFFF;
            hi  = a;
            dz  = 1'b1;
            lat = 1;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            lo = 16'h8000;
            hi = 16'h0000;
            ov = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[15:0];
            hi = r[15:0];
        end
    endtask

    // One full operation: single-cycle start pulse, bounded wait for done, result check
    task automatic runOp(input string tag, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] lo, input logic [15:0] hi, input logic dz, input logic ov,
                         input int lat);
        int k;
        int stallBad;
        bit found;
        stallBad = 0;
        found    = 1'b0;
        applyStimulus(f, a, b);
        #1;
        checkOutput({tag, ".stallAtStart"}, {31'd0, bus.o_stall}, 32'd1);
        @(negedge clk);
        bus.i_start = 1'b0;
        k = 1;
        while (k <= 40 && !found) begin
            #1;
            if (k == 1 && lat > 1) begin
                checkOutput({tag, ".flagsClear"}, {30'd0, bus.o_div_zero, bus.o_ovf}, 32'd0);
            end
            if (bus.o_done) begin
                found = 1'b1;
            end else begin
                if (!bus.o_stall || !bus.o_busy) stallBad++;
                @(negedge clk);
                k++;
            end
        end
        checkOutput({tag, ".latency"}, k, lat);
        checkOutput({tag, ".stallProfile"}, stallBad, 0);
        if (found) begin
            checkOutput({tag, ".stallAtDone"}, {31'd0, bus.o_stall}, 32'd0);
            checkOutput({tag, ".lo"}, {16'd0, bus.o_result_lo}, {16'd0, lo});
            checkOutput({tag, ".hi"}, {16'd0, bus.o_result_hi}, {16'd0, hi});
            checkOutput({tag, ".divZero"}, {31'd0, bus.o_div_zero}, {31'd0, dz});
            checkOutput({tag, ".ovf"}, {31'd0, bus.o_ovf}, {31'd0, ov});
            @(negedge clk);
            #1;
            checkOutput({tag, ".doneOnce"}, {30'd0, bus.o_done, bus.o_busy}, 32'd0);
            checkOutput({tag, ".hold"}, {bus.o_result_hi, bus.o_result_lo}, {hi, lo});
        end
    endtask

    initial begin
        logic [15:0] eLo;
        logic [15:0] eHi;
        logic        eDz;
        logic        eOv;
        int          eLat;
        int          doneCount;
        int          doneAt;
        int          lastDone;
        int          spacingBad;
        int          busyCount;
        logic [3:0]  rf;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0]  = '{F_MUL, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0, 1'b0, 18};
        vecs[1]  = '{F_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 18};
        vecs[2]  = '{F_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18};
        vecs[3]  = '{F_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1};
        vecs[4]  = '{F_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18};
        vecs[5]  = '{F_MUL, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b0, 18};
        vecs[6]  = '{F_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 18};
        vecs[7]  = '{F_DIV, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18};
        vecs[8]  = '{F_DIV, 16'h0003, 16'h0005, 16'h0000, 16'h0003, 1'b0, 1'b0, 18};
        vecs[9]  = '{F_MUL, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 18};
        vecs[10] = '{F_DIV, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 18};
        vecs[11] = '{F_MUL, 16'h7FFF, 16'h8000, 16'h8000, 16'hC000, 1'b0, 1'b0, 18};
        vecs[12] = '{F_DIV, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 18};

        bus.i_start = 1'b0;
        bus.i_func  = 4'b0000;
        bus.i_op_a  = '0;
        bus.i_op_b  = '0;
        reset       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.status", {29'd0, bus.o_busy, bus.o_stall, bus.o_done}, 32'd0);
        checkOutput("reset.results", {bus.o_result_hi, bus.o_result_lo}, 32'd0);
        checkOutput("reset.flags", {30'd0, bus.o_div_zero, bus.o_ovf}, 32'd0);
        reset = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 13; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].func, vecs[i].a, vecs[i].b,
                  vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].ov, vecs[i].lat);
        end

        $display("[TB] reset during RUN");
        applyStimulus(F_MUL, 16'h0007, 16'hFFFD);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midReset.status", {29'd0, bus.o_busy, bus.o_stall, bus.o_done}, 32'd0);
        checkOutput("midReset.results", {bus.o_result_hi, bus.o_result_lo}, 32'd0);
        checkOutput("midReset.flags", {30'd0, bus.o_div_zero, bus.o_ovf}, 32'd0);
        reset = 1'b1;
        runOp("afterReset", F_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 18);

        $display("[TB] invalid function code");
        applyStimulus(4'b0010, 16'h0005, 16'h0003);
        #1;
        checkOutput("invalid.stall", {31'd0, bus.o_stall}, 32'd0);
        busyCount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_busy || bus.o_done || bus.o_stall) busyCount++;
        end
        checkOutput("invalid.ignored", busyCount, 0);
        bus.i_start = 1'b0;

        $display("[TB] start repulsed during RUN");
        applyStimulus(F_MUL, 16'h0003, 16'h0005);
        doneCount = 0;
        doneAt    = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.i_start = (k == 3);
            if (k == 3) begin
                bus.i_op_a = 16'h0100;
                bus.i_op_b = 16'h0100;
            end
            #1;
            if (bus.o_done) begin
                doneCount++;
                doneAt = k;
                checkOutput("repulse.lo", {16'd0, bus.o_result_lo}, 32'h0000_000F);
            end
        end
        checkOutput("repulse.doneCount", doneCount, 1);
        checkOutput("repulse.doneAt", doneAt, 18);

        $display("[TB] start held continuously");
        applyStimulus(F_DIV, 16'h0064, 16'h0007);
        doneCount  = 0;
        lastDone   = 0;
        spacingBad = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_done) begin
                if (doneCount > 0 && (k - lastDone) != W + 3) spacingBad++;
                if (doneCount == 0 && k != W + 2) spacingBad++;
                if ({bus.o_result_hi, bus.o_result_lo} !== 32'h0002_000E) spacingBad++;
                doneCount++;
                lastDone = k;
            end
        end
        checkOutput("held.doneCount", doneCount, 4);
        checkOutput("held.spacing", spacingBad, 0);
        bus.i_start = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        checkOutput("held.idleAfter", {31'd0, bus.o_busy}, 32'd0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            rf = ($urandom_range(0, 1) == 0) ? F_MUL : F_DIV;
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 16'h0000;
                1: begin ra = 16'h8000; rb = 16'hFFFF; end
                2: ra = 16'h8000;
                3: rb = 16'($urandom_range(1, 7));
                default: ;
            endcase
            refModel(rf, ra, rb, eLo, eHi, eDz, eOv, eLat);
            runOp($sformatf("rand%0d", i), rf, ra, rb, eLo, eHi, eDz, eOv, eLat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
